axi_sramlike_bridge: RTL and testbench
======================================

Name: axi_sramlike_bridge

Overview:
Parametrised bridge from NPORT sram-like request ports (port 0 = instruction fetch, port 1 = data, further ports for future masters) to one AXI3 master interface. It generalises the fixed two-port inst/data bridge with three additions:
- a configurable number of ports;
- multiple outstanding reads per port;
- round-robin arbitration;
- read-after-write address hazard stalling.

It sits between the pipeline stages and the AXI ports in mycpu_top.

Parameters:
NPORT, 2, number of sram-like ports (1..8); port index is used as AXI ID.
RD_OST, 2, maximum outstanding reads per port (1..4).
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NPORT.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, synchronous, active-low.
req  in  NPORT  per-port request valid.
wr  in  NPORT  per-port write flag.
size  in  2*NPORT  per-port size (0 = byte, 1 = half, 2 = word).
wstrb  in  4*NPORT  per-port byte strobes.
addr  in  32*NPORT  per-port address.
wdata  in  32*NPORT  per-port write data.
addr_ok  out  NPORT  request accepted this cycle.
data_ok  out  NPORT  read data returned / write completed this cycle.
rdata_o  out  32  read data, valid for the port whose data_ok is high.
AR channel: arid[ID_W], araddr[32], arlen[8], arsize[3], arburst[2], arlock[2], arcache[4], arprot[3], arvalid (out); arready (in).
R channel: rid[ID_W], rdata[32], rresp[2], rlast, rvalid (in); rready (out).
AW channel: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid (out, same widths as AR); awready (in).
W channel: wid[ID_W], wdata_axi[32], wstrb_axi[4], wlast, wvalid (out); wready (in).
B channel: bid[ID_W], bresp[2], bvalid (in); bready (out).

Behaviour:
- Reset (aresetn = 0 at a clock edge) clears all state:
  - arvalid = awvalid = wvalid = 0; addr_ok = data_ok = 0.
  - Outstanding counters = 0; write-pending flag = 0; round-robin pointers = 0.
  - In-flight transactions are dropped.
- Constant outputs: arlen = awlen = 0, arburst = awburst = 2'b01, arlock = awlock = 0, arcache = awcache = 0, arprot = awprot = 0, wlast = 1, rready = 1, bready = 1.
- arsize / awsize = {1'b0, size}.
- Read eligibility: port p is read-eligible when all of the following hold:
  - req[p] && !wr[p];
  - rd_cnt[p] < RD_OST;
  - the AR holding register is empty;
  - no RAW hazard (see below).
- Write eligibility: port p is write-eligible when req[p] && wr[p] && write-pending flag = 0.
- Arbitration: two independent round-robin arbiters, one for reads and one for writes. Per cycle, at most one read accept and one write accept, on distinct ports. A port wins on its own kind only. Each pointer advances to winner+1 (mod NPORT) on a grant.
- addr_ok[p] is combinational: it is high in the cycle p wins. The request fields are captured at that clock edge.
- AR path:
  - Grant loads the AR register with arid = p and araddr = addr[p].
  - arvalid rises the next cycle and holds until arready.
  - On the grant edge, rd_cnt[p] increments.
- AW/W path:
  - Grant loads the AW and W registers and sets write-pending.
  - awvalid and wvalid rise together the next cycle; each deasserts independently on its own ready.
  - A write completes on bvalid: data_ok[bid] pulses for 1 cycle and write-pending clears. The port may issue its next write that same cycle.
- R path:
  - rvalid with rid = p pulses data_ok[p] with rdata_o = rdata in the same cycle (combinational, 0 added latency); rd_cnt[p] decrements.
  - Responses per port return in order because the port uses a single ID.
  - A read accept and a read return on the same port in the same cycle leave rd_cnt unchanged.
  - rresp and bresp are ignored.
- If bvalid and an R return target the same port in the same cycle:
  - data_ok for that port is asserted once, and the port disambiguates by its own pending kind.
  - Ports never hold a read and a write outstanding at once; stage logic guarantees this.
- RAW hazard: a read request is stalled (addr_ok = 0) while write-pending = 1 and addr[p][31:2] equals the pending write address [31:2].
- Undefined responses: rvalid with rid >= NPORT, or bvalid when no write is pending, is ignored.

Decomposition:
- Shared package: AXI constant encodings (BURST_INCR, size codes), port-slice helper constants, and the ID_W default.
- One sub-module: rr_arbiter, parametrised by NPORT. Inputs are a request vector and an enable; outputs are a one-hot grant and the updated pointer. It is instantiated twice, once for reads and once for writes.

Test Plan:
- Single read: port0 req, addr = 0xBFC0_0000, size = 2. Required: addr_ok same cycle; arvalid next cycle with arid = 0; arready = 1; rvalid, rid = 0, rdata = 0x2408_0001 two cycles later. Then data_ok[0] = 1 and rdata_o = 0x2408_0001 in that cycle, and rd_cnt[0] returns to 0.
- Outstanding limit, RD_OST = 2: port0 issues 3 back-to-back reads with no R returns. Required: the third addr_ok is held 0 until the first rvalid with rid = 0, then it is accepted.
- Round-robin: ports 0 and 1 both request reads continuously with arready = 1. Required: grants alternate 0, 1, 0, 1, starting from port 0 after reset.
- Write and RAW hazard:
  - Stimulus: port1 writes addr = 0x8000_0010, wstrb = 4'b0011, wdata = 0x1234_5678, with awready delayed 3 cycles and wready = 1; port1 then reads 0x8000_0012.
  - Required: wvalid drops after 1 cycle; awvalid holds for 3 cycles; the read addr_ok stays 0 until the bvalid cycle; data_ok[1] pulses on bvalid.
- Reset mid-operation: aresetn = 0 for one edge while arvalid = 1 and rd_cnt[1] = 1. Required: next cycle arvalid = 0, all counters 0, data_ok = 0, and a new read is accepted immediately after release.

Source files
------------

// File: rtl/axi_sramlike_bridge_pkg.sv
// Shared constants for the sram-like to AXI3 bridge: AXI encodings, bus widths,
// sram-like size codes and small width helpers.
package axi_sramlike_bridge_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int ID_W_DEF = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } sram_size_e;

    function automatic logic [2:0] axsize(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

    // Pointer width that stays legal for a single-port build.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_sramlike_bridge_if.sv
// AXI3 master bus between the bridge (master modport) and the interconnect
// or memory model (slave modport).
interface axi_sramlike_bridge_if #(
    parameter int ID_W = axi_sramlike_bridge_pkg::ID_W_DEF
);
    import axi_sramlike_bridge_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata_axi;
    logic [STRB_W-1:0] wstrb_axi;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata_axi, wstrb_axi, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata_axi, wstrb_axi, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_sramlike_bridge_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the pointer onward,
// pointer moves to winner+1 on any grant; no grant while en is low.
module rr_arbiter
    import axi_sramlike_bridge_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int PW    = ptr_w(NPORT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req,
    input  logic             en,
    output logic [NPORT-1:0] grant,
    output logic [PW-1:0]    ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // Two passes: ports at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr_q;
        found   = 1'b0;
        for (int j = 0; j < NPORT; j++) begin
            if (en && !found && req[j] && (int'(ptr_q) <= j)) begin
                grant[j] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (j == NPORT - 1) ? '0 : PW'(j + 1);
            end
        end
        for (int j = 0; j < NPORT; j++) begin
            if (en && !found && req[j] && (int'(ptr_q) > j)) begin
                grant[j] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (j == NPORT - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_nxt;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/axi_sramlike_bridge.sv
// NPORT sram-like ports onto one AXI3 master: addr_ok is combinational, AR/AW/W are
// registered (issue 1 cycle after accept), data_ok is combinational from R/B.
module axi_sramlike_bridge
    import axi_sramlike_bridge_pkg::*;
#(
    parameter int NPORT  = 2,
    parameter int RD_OST = 2,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wr,
    input  logic [2*NPORT-1:0]      size,
    input  logic [4*NPORT-1:0]      wstrb,
    input  logic [32*NPORT-1:0]     addr,
    input  logic [32*NPORT-1:0]     wdata,
    output logic [NPORT-1:0]        addr_ok,
    output logic [NPORT-1:0]        data_ok,
    output logic [31:0]             rdata_o,
    axi_sramlike_bridge_if.master   axi
);

    localparam int CW = $clog2(RD_OST + 1);
    localparam int PW = ptr_w(NPORT);

    logic [CW-1:0]     rd_cnt [NPORT];
    logic              ar_vld;
    logic [ID_W-1:0]   ar_id;
    logic [31:0]       ar_addr;
    logic [2:0]        ar_size;
    logic              aw_vld;
    logic              w_vld;
    logic              wr_pend;
    logic [ID_W-1:0]   aw_id;
    logic [31:0]       aw_addr;
    logic [2:0]        aw_size;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              r_hit;
    logic              b_done;
    logic              wr_busy;
    logic [NPORT-1:0]  rd_elig;
    logic [NPORT-1:0]  wr_elig;
    logic [NPORT-1:0]  rd_gnt;
    logic [NPORT-1:0]  wr_gnt;
    logic [NPORT-1:0]  rd_ret;
    logic [PW-1:0]     unused_rd_ptr;
    logic [PW-1:0]     unused_wr_ptr;
    logic              unused_resp;

    assign r_hit   = axi.rvalid && (32'(axi.rid) < NPORT);
    assign b_done  = aresetn && wr_pend && axi.bvalid && (32'(axi.bid) < NPORT);
    // A completing write frees both the write slot and the RAW hazard in its B cycle.
    assign wr_busy = wr_pend && !b_done;

    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        rd_ret  = '0;
        data_ok = '0;
        for (int p = 0; p < NPORT; p++) begin
            rd_elig[p] = req[p] && !wr[p] && (32'(rd_cnt[p]) < RD_OST)
                         && !(wr_busy && (addr[p*32+2 +: 30] == aw_addr[31:2]));
            wr_elig[p] = req[p] && wr[p];
            rd_ret[p]  = r_hit && (32'(axi.rid) == p);
            data_ok[p] = aresetn && (rd_ret[p] || (b_done && (32'(axi.bid) == p)));
        end
    end

    rr_arbiter #(.NPORT(NPORT), .PW(PW)) u_rd_arb (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (rd_elig),
        .en    (aresetn && !ar_vld),
        .grant (rd_gnt),
        .ptr   (unused_rd_ptr)
    );

    rr_arbiter #(.NPORT(NPORT), .PW(PW)) u_wr_arb (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (wr_elig),
        .en    (aresetn && !wr_busy),
        .grant (wr_gnt),
        .ptr   (unused_wr_ptr)
    );

    assign addr_ok = rd_gnt | wr_gnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ar_vld  <= 1'b0;
            ar_id   <= '0;
            ar_addr <= '0;
            ar_size <= '0;
        end else begin
            if (axi.arready) ar_vld <= 1'b0;
            for (int p = 0; p < NPORT; p++) begin
                if (rd_gnt[p]) begin
                    ar_vld  <= 1'b1;
                    ar_id   <= ID_W'(p);
                    ar_addr <= addr[p*32 +: 32];
                    ar_size <= axsize(size[p*2 +: 2]);
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_vld  <= 1'b0;
            w_vld   <= 1'b0;
            wr_pend <= 1'b0;
            aw_id   <= '0;
            aw_addr <= '0;
            aw_size <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (axi.awready) aw_vld  <= 1'b0;
            if (axi.wready)  w_vld   <= 1'b0;
            if (b_done)      wr_pend <= 1'b0;
            for (int p = 0; p < NPORT; p++) begin
                if (wr_gnt[p]) begin
                    aw_vld  <= 1'b1;
                    w_vld   <= 1'b1;
                    wr_pend <= 1'b1;
                    aw_id   <= ID_W'(p);
                    aw_addr <= addr[p*32 +: 32];
                    aw_size <= axsize(size[p*2 +: 2]);
                    w_data  <= wdata[p*32 +: 32];
                    w_strb  <= wstrb[p*4 +: 4];
                end
            end
        end
    end

    // Same-cycle accept and return on one port cancel out.
    always_ff @(posedge aclk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!aresetn) begin
                rd_cnt[p] <= '0;
            end else if (rd_gnt[p] && !rd_ret[p]) begin
                rd_cnt[p] <= rd_cnt[p] + 1'b1;
            end else if (!rd_gnt[p] && rd_ret[p] && (rd_cnt[p] != '0)) begin
                rd_cnt[p] <= rd_cnt[p] - 1'b1;
            end
        end
    end

    assign axi.arid      = ar_id;
    assign axi.araddr    = ar_addr;
    assign axi.arlen     = LEN_SINGLE;
    assign axi.arsize    = ar_size;
    assign axi.arburst   = BURST_INCR;
    assign axi.arlock    = '0;
    assign axi.arcache   = '0;
    assign axi.arprot    = '0;
    assign axi.arvalid   = ar_vld;
    assign axi.rready    = 1'b1;
    assign axi.awid      = aw_id;
    assign axi.awaddr    = aw_addr;
    assign axi.awlen     = LEN_SINGLE;
    assign axi.awsize    = aw_size;
    assign axi.awburst   = BURST_INCR;
    assign axi.awlock    = '0;
    assign axi.awcache   = '0;
    assign axi.awprot    = '0;
    assign axi.awvalid   = aw_vld;
    assign axi.wid       = aw_id;
    assign axi.wdata_axi = w_data;
    assign axi.wstrb_axi = w_strb;
    assign axi.wlast     = 1'b1;
    assign axi.wvalid    = w_vld;
    assign axi.bready    = 1'b1;

    assign rdata_o     = axi.rdata;
    assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

endmodule

// File: tb/tb_axi_sramlike_bridge.sv
// Directed bench for axi_sramlike_bridge: expected AR/AW/W beats and data_ok
// responses are queued by the stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_axi_sramlike_bridge;
    import axi_sramlike_bridge_pkg::*;

    localparam int NPORT  = 2;
    localparam int RD_OST = 2;
    localparam int ID_W   = 4;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [NPORT-1:0]    req, wr;
    logic [2*NPORT-1:0]  size;
    logic [4*NPORT-1:0]  wstrb;
    logic [32*NPORT-1:0] addr, wdata;
    logic [NPORT-1:0]    addr_ok, data_ok;
    logic [31:0]         rdata_o;

    axi_sramlike_bridge_if #(.ID_W(ID_W)) axi();

    axi_sramlike_bridge #(.NPORT(NPORT), .RD_OST(RD_OST), .ID_W(ID_W)) dut (
        .aclk(clk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata_o(rdata_o), .axi(axi)
    );

    typedef struct { int port; bit is_rd; logic [31:0] data; } ok_t;
    typedef struct { int id; logic [31:0] a; logic [2:0] sz; } ax_t;
    typedef struct { int id; logic [31:0] d; logic [3:0] strb; } w_t;

    ok_t exp_ok[$];
    ax_t exp_ar[$], exp_aw[$];
    w_t  exp_w[$];
    ok_t e_ok;
    ax_t e_ax;
    w_t  e_w;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  grants[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT produced a beat with no expected entry", name);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (data_ok[p]) begin
                if (exp_ok.size() == 0) unexpected("data_ok");
                else begin
                    e_ok = exp_ok.pop_front();
                    check("data_ok_port", p, e_ok.port);
                    if (e_ok.is_rd) check("rdata_o", rdata_o, e_ok.data);
                end
            end
        end
        if (axi.arvalid && axi.arready) begin
            if (exp_ar.size() == 0) unexpected("ar_beat");
            else begin
                e_ax = exp_ar.pop_front();
                check("ar_beat", {axi.arid, axi.araddr, axi.arsize}, {ID_W'(e_ax.id), e_ax.a, e_ax.sz});
            end
        end
        if (axi.awvalid && axi.awready) begin
            if (exp_aw.size() == 0) unexpected("aw_beat");
            else begin
                e_ax = exp_aw.pop_front();
                check("aw_beat", {axi.awid, axi.awaddr, axi.awsize}, {ID_W'(e_ax.id), e_ax.a, e_ax.sz});
            end
        end
        if (axi.wvalid && axi.wready) begin
            if (exp_w.size() == 0) unexpected("w_beat");
            else begin
                e_w = exp_w.pop_front();
                check("w_beat", {axi.wid, axi.wdata_axi, axi.wstrb_axi, axi.wlast},
                      {ID_W'(e_w.id), e_w.d, e_w.strb, 1'b1});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [31:0] a);
        req[p] = 1'b1;
        wr[p]  = 1'b0;
        addr[p*32 +: 32] = a;
        size[p*2 +: 2]   = SIZE_WORD;
    endtask

    // Entered just after a posedge with req[p] already raised; leaves just after the grant edge.
    task automatic wait_accept(input int p, input string name, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!addr_ok[p] && k < budget) begin
            cyc();
            @(negedge clk);
            k++;
        end
        check(name, addr_ok[p], 1);
        cyc();
        req[p] = 1'b0;
    endtask

    task automatic r_ret(input int id, input logic [31:0] d);
        exp_ok.push_back('{port: id, is_rd: 1'b1, data: d});
        axi.rvalid = 1'b1;
        axi.rid    = ID_W'(id);
        axi.rdata  = d;
        cyc();
        axi.rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b1;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;

        // Reset holds everything quiet even with a request and an R beat present.
        set_rd(0, 32'hBFC0_0000);
        axi.rvalid = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_addr_ok", addr_ok, 0);
        check("rst_data_ok", data_ok, 0);
        check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b000);
        check("const_ax", {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot,
                           axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
              {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        check("const_misc", {axi.wlast, axi.rready, axi.bready}, 3'b111);
        cyc();
        aresetn = 1'b1; req = '0; axi.rvalid = 1'b0;
        cyc();

        // Single read
        set_rd(0, 32'hBFC0_0000);
        exp_ar.push_back('{id: 0, a: 32'hBFC0_0000, sz: 3'b010});
        wait_accept(0, "t1_addr_ok", 0);
        @(negedge clk);
        check("t1_arvalid", axi.arvalid, 1);
        cyc();
        @(negedge clk);
        check("t1_arvalid_drop", axi.arvalid, 0);
        cyc();
        r_ret(0, 32'h2408_0001);
        @(negedge clk);
        check("t1_rd_cnt", dut.rd_cnt[0], 0);
        cyc();

        // Outstanding limit
        set_rd(0, 32'h0000_1000);
        exp_ar.push_back('{id: 0, a: 32'h0000_1000, sz: 3'b010});
        wait_accept(0, "t2_rd1", 0);
        set_rd(0, 32'h0000_1004);
        exp_ar.push_back('{id: 0, a: 32'h0000_1004, sz: 3'b010});
        wait_accept(0, "t2_rd2", 3);
        set_rd(0, 32'h0000_1008);
        exp_ar.push_back('{id: 0, a: 32'h0000_1008, sz: 3'b010});
        repeat (4) begin
            @(negedge clk);
            check("t2_ost_stall", addr_ok[0], 0);
            cyc();
        end
        r_ret(0, 32'hA000_0001);
        wait_accept(0, "t2_third_accept", 0);
        cyc();
        r_ret(0, 32'hA000_0002);
        r_ret(0, 32'hA000_0003);
        @(negedge clk);
        check("t2_rd_cnt", dut.rd_cnt[0], 0);
        cyc();

        // Round-robin from a fresh reset
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        exp_ar.push_back('{id: 0, a: 32'h0000_2000, sz: 3'b010});
        exp_ar.push_back('{id: 1, a: 32'h0000_3000, sz: 3'b010});
        exp_ar.push_back('{id: 0, a: 32'h0000_2000, sz: 3'b010});
        exp_ar.push_back('{id: 1, a: 32'h0000_3000, sz: 3'b010});
        set_rd(0, 32'h0000_2000);
        set_rd(1, 32'h0000_3000);
        for (int k = 0; k < 20 && grants.size() < 4; k++) begin
            @(negedge clk);
            for (int p = 0; p < NPORT; p++) if (addr_ok[p]) grants.push_back(p);
            cyc();
        end
        req = '0;
        check("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("t3_order", grants[i], i % 2);
        cyc();
        r_ret(0, 32'hB000_0000);
        r_ret(0, 32'hB000_0001);
        r_ret(1, 32'hB100_0000);
        r_ret(1, 32'hB100_0001);

        // Write with delayed AW, then a hazarding read from the same port
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        req[1] = 1'b1; wr[1] = 1'b1;
        addr[32 +: 32] = 32'h8000_0010; size[2 +: 2] = SIZE_HALF;
        wstrb[4 +: 4] = 4'b0011; wdata[32 +: 32] = 32'h1234_5678;
        exp_aw.push_back('{id: 1, a: 32'h8000_0010, sz: 3'b001});
        exp_w.push_back('{id: 1, d: 32'h1234_5678, strb: 4'b0011});
        wait_accept(1, "t4_wr_accept", 0);
        set_rd(1, 32'h8000_0012);
        @(negedge clk);
        check("t4_c1_aw_w", {axi.awvalid, axi.wvalid}, 2'b11);
        check("t4_c1_raw", addr_ok[1], 0);
        cyc();
        @(negedge clk);
        check("t4_c2_aw_w", {axi.awvalid, axi.wvalid}, 2'b10);
        check("t4_c2_raw", addr_ok[1], 0);
        cyc();
        axi.awready = 1'b1;
        @(negedge clk);
        check("t4_c3_aw_w", {axi.awvalid, axi.wvalid}, 2'b10);
        check("t4_c3_raw", addr_ok[1], 0);
        cyc();
        @(negedge clk);
        check("t4_c4_aw_w", {axi.awvalid, axi.wvalid}, 2'b00);
        check("t4_c4_raw", addr_ok[1], 0);
        cyc();
        axi.bvalid = 1'b1; axi.bid = 4'd1;
        exp_ok.push_back('{port: 1, is_rd: 1'b0, data: 32'h0});
        exp_ar.push_back('{id: 1, a: 32'h8000_0012, sz: 3'b010});
        @(negedge clk);
        check("t4_raw_release", addr_ok[1], 1);
        cyc();
        axi.bvalid = 1'b0; req[1] = 1'b0;
        cyc();
        r_ret(1, 32'hCAFE_F00D);

        // Reset while an AR is stuck and port 1 has one read outstanding
        axi.arready = 1'b0;
        set_rd(1, 32'h0000_4000);
        wait_accept(1, "t5_accept", 0);
        @(negedge clk);
        check("t5_arvalid_pre", axi.arvalid, 1);
        check("t5_rd_cnt_pre", dut.rd_cnt[1], 1);
        cyc();
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        axi.arready = 1'b1;
        set_rd(1, 32'h0000_5000);
        exp_ar.push_back('{id: 1, a: 32'h0000_5000, sz: 3'b010});
        @(negedge clk);
        check("t5_arvalid_cleared", axi.arvalid, 0);
        check("t5_rd_cnt_cleared", {dut.rd_cnt[0], dut.rd_cnt[1]}, 0);
        check("t5_data_ok", data_ok, 0);
        check("t5_new_accept", addr_ok[1], 1);
        cyc();
        req[1] = 1'b0;
        cyc();
        r_ret(1, 32'h5555_AAAA);

        // Stray responses: B with nothing pending, R with an out-of-range ID
        axi.bvalid = 1'b1; axi.bid = 4'd0;
        axi.rvalid = 1'b1; axi.rid = 4'd3; axi.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("undef_resp", data_ok, 0);
        cyc();
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;

        repeat (3) cyc();
        check("sb_ok_drained", exp_ok.size(), 0);
        check("sb_ar_drained", exp_ar.size(), 0);
        check("sb_aw_drained", exp_aw.size(), 0);
        check("sb_w_drained", exp_w.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
